pipe_stage_regs: RTL and testbench
==================================

# pipe_stage_regs

Holds the front-end pipeline registers of the pipelined MIPS core: the PC register (fetch), the IF/ID register and the ID/EX register. It applies the hazard controls produced by the hazard unit (stall_f, stall_d, clr_e) and the decode-stage redirect (pc_src_d). It also keeps saturating stall and flush event counters for performance and debug. It sits between fetch/decode datapath logic and the execute stage, and it drives the instr_d, instr_e and rf_wa_e values that the hazard unit consumes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc_f on reset
- CTRL_W, 12, width of the decode control bundle carried into EX

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_f  in  1  hold PC register
- stall_d  in  1  hold IF/ID register
- clr_e  in  1  flush ID/EX register to bubble
- pc_src_d  in  1  taken branch/jump resolved in decode; flushes IF/ID
- cnt_clr  in  1  synchronous clear of both counters
- pc_next_f  in  32  next PC from fetch mux
- instr_f  in  32  instruction from instruction memory
- pc_plus4_f  in  32  pc_f + 4
- ctrl_d  in  CTRL_W  decoded control bundle (bit 0 = we_reg)
- rd1_d, rd2_d  in  32 each  register-file read data
- sext_imm_d  in  32  sign-extended immediate
- rf_wa_d  in  5  destination register address
- pc_f  out  32  current fetch PC
- instr_d, pc_plus4_d  out  32 each  IF/ID contents
- valid_d  out  1  IF/ID holds a real instruction
- instr_e, rd1_e, rd2_e, sext_imm_e  out  32 each  ID/EX contents
- ctrl_e  out  CTRL_W  ID/EX control bundle
- rf_wa_e  out  5  ID/EX destination address
- valid_e  out  1  ID/EX holds a real instruction
- stall_cnt, flush_cnt  out  16 each  saturating event counters

## Operation
- Reset (rst_n=0): pc_f=RESET_PC. All other outputs are 0, including both valid bits and both counters.
- PC register: if stall_f=1, hold; otherwise pc_f <= pc_next_f.
- IF/ID register, in priority order:
  - stall_d=1: hold all fields, including valid_d.
  - else pc_src_d=1: clear. instr_d=0 (NOP), pc_plus4_d=0, valid_d=0.
  - else load instr_f and pc_plus4_f, and set valid_d=1.
- Stall wins over redirect because a branch held in decode is not resolved yet. pc_src_d asserted while stall_d=1 is ignored.
- ID/EX register:
  - clr_e=1: bubble. Every field is 0, so ctrl_e=0 (we_reg=0), rf_wa_e=0, instr_e=0 and valid_e=0.
  - else load instr_d, ctrl_d, rd1_d, rd2_d, sext_imm_d and rf_wa_d, and set valid_e=valid_d.
  - ID/EX has no hold; EX never stalls.
  - Invalid-slot masking: when valid_d=0 and clr_e=0, ctrl_e is also forced to 0. This keeps squashed slots from asserting we_reg.
- stall_f and stall_d are independent inputs. Any combination is legal and each register obeys only its own control.
- stall_cnt: +1 on every cycle with stall_d=1. Saturates at 16'hFFFF.
- flush_cnt: +1 on every cycle where clr_e=1 or (pc_src_d=1 and stall_d=0). Both events in the same cycle count as one. Saturates at 16'hFFFF.
- cnt_clr=1 zeroes both counters on the next edge. It takes priority over increments in the same cycle.

## Timing
- Every output is registered, with one-cycle latency from input to output. There are no combinational paths from inputs to outputs.
- A control sampled at edge N takes effect on the outputs just after edge N. A stall held for k cycles freezes the register for k edges.
- Reset assertion clears state immediately, without waiting for clk. This includes mid-stall and mid-flush: no pending hold or flush survives reset.
- First edge after rst_n rises:
  - pc_f=pc_next_f (if stall_f=0).
  - IF/ID loads instr_f.
  - ID/EX loads the reset-valued IF/ID contents, which is a bubble (valid_d=0 forces ctrl_e=0).
- Counter saturation: at 16'hFFFF further events leave the value unchanged. There is no wrap to 0.

## Test plan
- Reset: hold rst_n=0 with RESET_PC=32'h0040_0000 -> pc_f=32'h0040_0000, all other outputs 0. Release, pc_next_f=32'h0040_0004 -> pc_f=32'h0040_0004 after one edge.
- Load-use stall: stall_f=stall_d=clr_e=1 for 1 cycle with instr_d=32'h8C08_0000 held -> pc_f and instr_d unchanged, ctrl_e=0, rf_wa_e=0, valid_e=0, stall_cnt=1, flush_cnt=1.
- Branch redirect: pc_src_d=1, stall_d=0, instr_f=32'h2009_0005 -> instr_d=0, valid_d=0. Next cycle ctrl_e=0 even with ctrl_d bit0=1. flush_cnt=1.
- Stall beats redirect: stall_d=1 and pc_src_d=1 together -> instr_d and valid_d held, flush_cnt unchanged, stall_cnt +1.
- Counter saturation/clear: drive stall_d=1 for 65540 cycles -> stall_cnt=16'hFFFF. Assert cnt_clr with stall_d=1 -> stall_cnt=0 next edge.
- Async reset mid-stall: assert rst_n=0 between edges during a stall -> outputs reach reset values before the next rising clk edge.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs
// ---------------------------------------------------------------------------
// This module holds the front-end pipeline registers of the pipelined MIPS core:
//   - the PC register (fetch stage),
//   - the IF/ID register, which can hold (stall_d) or squash (pc_src_d),
//   - the ID/EX register, which can bubble (clr_e) but never holds.
// It also keeps two saturating 16-bit event counters:
//   - stall_cnt counts cycles with decode stalled,
//   - flush_cnt counts cycles with any flush event.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   stall_f, stall_d  hold the PC register / the IF/ID register
//   clr_e             flush ID/EX to a bubble
//   pc_src_d          taken redirect from decode; squashes IF/ID
//   cnt_clr           synchronous clear of both counters
//   pc_next_f, instr_f, pc_plus4_f                  fetch-side inputs
//   ctrl_d, rd1_d, rd2_d, sext_imm_d, rf_wa_d       decode-side inputs
//   pc_f                                            current fetch PC
//   instr_d, pc_plus4_d, valid_d                    IF/ID contents
//   instr_e, ctrl_e, rd1_e, rd2_e, sext_imm_e,
//   rf_wa_e, valid_e                                ID/EX contents
//   stall_cnt, flush_cnt                            saturating event counters
//
// Every output comes straight from a flop. No path from an input to an
// output is combinational.
// ---------------------------------------------------------------------------
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              clr_e,
    input  logic              pc_src_d,
    input  logic              cnt_clr,
    input  logic [31:0]       pc_next_f,
    input  logic [31:0]       instr_f,
    input  logic [31:0]       pc_plus4_f,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [31:0]       rd1_d,
    input  logic [31:0]       rd2_d,
    input  logic [31:0]       sext_imm_d,
    input  logic [4:0]        rf_wa_d,
    output logic [31:0]       pc_f,
    output logic [31:0]       instr_d,
    output logic [31:0]       pc_plus4_d,
    output logic              valid_d,
    output logic [31:0]       instr_e,
    output logic [31:0]       rd1_e,
    output logic [31:0]       rd2_e,
    output logic [31:0]       sext_imm_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [4:0]        rf_wa_e,
    output logic              valid_e,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Fetch stage
    logic [31:0]       pc_q, pc_d;

    // IF/ID register
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;

    // ID/EX register
    logic [31:0]       idex_instr_q, idex_instr_d;
    logic [31:0]       idex_rd1_q, idex_rd1_d;
    logic [31:0]       idex_rd2_q, idex_rd2_d;
    logic [31:0]       idex_imm_q, idex_imm_d;
    logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
    logic [4:0]        idex_wa_q, idex_wa_d;
    logic              idex_valid_q, idex_valid_d;

    // Counters
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [15:0]       flush_cnt_q, flush_cnt_d;

    // A redirect only squashes IF/ID when decode is not stalled. A redirect
    // that coincides with a bubble counts as one flush event, not two.
    logic              flush_evt;
    assign flush_evt = clr_e | (pc_src_d & ~stall_d);

    // PC register
    always_comb begin
        pc_d = pc_q;
        if (!stall_f) begin
            pc_d = pc_next_f;
        end
    end

    // IF/ID register: stall beats redirect because a branch that is held in
    // decode has not been resolved yet.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (stall_d) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
            ifid_valid_d = ifid_valid_q;
        end else if (pc_src_d) begin
            ifid_instr_d = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d = instr_f;
            ifid_pc4_d   = pc_plus4_f;
            ifid_valid_d = 1'b1;
        end
    end

    // ID/EX register: either bubble or load, never hold.
    always_comb begin
        idex_instr_d = ifid_instr_q;
        idex_rd1_d   = rd1_d;
        idex_rd2_d   = rd2_d;
        idex_imm_d   = sext_imm_d;
        idex_wa_d    = rf_wa_d;
        idex_valid_d = ifid_valid_q;
        // A squashed decode slot must not carry live control (e.g. we_reg)
        // into EX, even though its other fields pass through.
        idex_ctrl_d  = ifid_valid_q ? ctrl_d : '0;
        if (clr_e) begin
            idex_instr_d = 32'h0;
            idex_rd1_d   = 32'h0;
            idex_rd2_d   = 32'h0;
            idex_imm_d   = 32'h0;
            idex_wa_d    = 5'd0;
            idex_valid_d = 1'b0;
            idex_ctrl_d  = '0;
        end
    end

    // Saturating counters. A clear wins over an increment in the same cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = 16'h0;
            flush_cnt_d = 16'h0;
        end else begin
            if (stall_d && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (flush_evt && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            idex_instr_q <= 32'h0;
            idex_rd1_q   <= 32'h0;
            idex_rd2_q   <= 32'h0;
            idex_imm_q   <= 32'h0;
            idex_ctrl_q  <= '0;
            idex_wa_q    <= 5'd0;
            idex_valid_q <= 1'b0;
            stall_cnt_q  <= 16'h0;
            flush_cnt_q  <= 16'h0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            idex_instr_q <= idex_instr_d;
            idex_rd1_q   <= idex_rd1_d;
            idex_rd2_q   <= idex_rd2_d;
            idex_imm_q   <= idex_imm_d;
            idex_ctrl_q  <= idex_ctrl_d;
            idex_wa_q    <= idex_wa_d;
            idex_valid_q <= idex_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign pc_f       = pc_q;
    assign instr_d    = ifid_instr_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;
    assign instr_e    = idex_instr_q;
    assign rd1_e      = idex_rd1_q;
    assign rd2_e      = idex_rd2_q;
    assign sext_imm_e = idex_imm_q;
    assign ctrl_e     = idex_ctrl_q;
    assign rf_wa_e    = idex_wa_q;
    assign valid_e    = idex_valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs
// ---------------------------------------------------------------------------
// This is a directed bench for pipe_stage_regs, built with RESET_PC = 32'h0040_0000.
// Each scenario task drives inputs just after a rising edge and checks the
// registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_regs;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          CW     = 12;

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic          stall_f, stall_d, clr_e, pc_src_d, cnt_clr;
    logic [31:0]   pc_next_f, instr_f, pc_plus4_f;
    logic [CW-1:0] ctrl_d;
    logic [31:0]   rd1_d, rd2_d, sext_imm_d;
    logic [4:0]    rf_wa_d;
    logic [31:0]   pc_f, instr_d, pc_plus4_d;
    logic          valid_d;
    logic [31:0]   instr_e, rd1_e, rd2_e, sext_imm_e;
    logic [CW-1:0] ctrl_e;
    logic [4:0]    rf_wa_e;
    logic          valid_e;
    logic [15:0]   stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    pipe_stage_regs #(.RESET_PC(RST_PC), .CTRL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_f(stall_f), .stall_d(stall_d), .clr_e(clr_e),
        .pc_src_d(pc_src_d), .cnt_clr(cnt_clr),
        .pc_next_f(pc_next_f), .instr_f(instr_f), .pc_plus4_f(pc_plus4_f),
        .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .sext_imm_d(sext_imm_d), .rf_wa_d(rf_wa_d),
        .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .instr_e(instr_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .sext_imm_e(sext_imm_e), .ctrl_e(ctrl_e), .rf_wa_e(rf_wa_e),
        .valid_e(valid_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_idle();
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        clr_e    = 1'b0;
        pc_src_d = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ctrl_idle();
        pc_next_f  = 32'h0040_0004;
        instr_f    = 32'h8C08_0000;
        pc_plus4_f = 32'h0040_0004;
        ctrl_d     = 12'hFFF;
        rd1_d      = 32'h1111_1111;
        rd2_d      = 32'h2222_2222;
        sext_imm_d = 32'h3333_3333;
        rf_wa_d    = 5'd9;
        step();
        step();
        n_tests++; if (pc_f !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_f, RST_PC); end
        n_tests++; if (instr_d !== 32'h0 || pc_plus4_d !== 32'h0 || valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_ifid: got %h/%h/%b expected 0/0/0", instr_d, pc_plus4_d, valid_d); end
        n_tests++; if (instr_e !== 32'h0 || rd1_e !== 32'h0 || rd2_e !== 32'h0 || sext_imm_e !== 32'h0) begin n_fail++; $display("FAIL reset_idex_data: got %h/%h/%h/%h expected all 0", instr_e, rd1_e, rd2_e, sext_imm_e); end
        n_tests++; if (ctrl_e !== 12'h0 || rf_wa_e !== 5'd0 || valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_idex_ctrl: got %h/%h/%b expected 0/0/0", ctrl_e, rf_wa_e, valid_e); end
        n_tests++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", stall_cnt, flush_cnt); end
        rst_n = 1'b1;
        step();
        n_tests++; if (pc_f !== 32'h0040_0004) begin n_fail++; $display("FAIL first_pc: got %h expected 00400004", pc_f); end
        n_tests++; if (instr_d !== 32'h8C08_0000 || valid_d !== 1'b1) begin n_fail++; $display("FAIL first_ifid: got %h/%b expected 8c080000/1", instr_d, valid_d); end
        n_tests++; if (ctrl_e !== 12'h0 || valid_e !== 1'b0 || instr_e !== 32'h0) begin n_fail++; $display("FAIL first_bubble: got ctrl %h valid %b instr %h expected 0/0/0", ctrl_e, valid_e, instr_e); end
    endtask

    task automatic test_load_use();
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        clr_e     = 1'b1;
        pc_next_f = 32'h0040_0008;
        instr_f   = 32'h1234_5678;
        step();
        n_tests++; if (pc_f !== 32'h0040_0004) begin n_fail++; $display("FAIL lu_pc_hold: got %h expected 00400004", pc_f); end
        n_tests++; if (instr_d !== 32'h8C08_0000 || valid_d !== 1'b1) begin n_fail++; $display("FAIL lu_ifid_hold: got %h/%b expected 8c080000/1", instr_d, valid_d); end
        n_tests++; if (ctrl_e !== 12'h0 || rf_wa_e !== 5'd0 || valid_e !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %h/%h/%b expected 0/0/0", ctrl_e, rf_wa_e, valid_e); end
        n_tests++; if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d/%0d expected 1/1", stall_cnt, flush_cnt); end
        ctrl_idle();
    endtask

    task automatic test_normal_flow();
        pc_next_f  = 32'h0040_0008;
        instr_f    = 32'h0109_5020;
        pc_plus4_f = 32'h0040_0008;
        ctrl_d     = 12'h0A5;
        rd1_d      = 32'hAAAA_0001;
        rd2_d      = 32'hBBBB_0002;
        sext_imm_d = 32'hFFFF_FFFC;
        rf_wa_d    = 5'd10;
        step();
        n_tests++; if (pc_f !== 32'h0040_0008) begin n_fail++; $display("FAIL nf_pc: got %h expected 00400008", pc_f); end
        n_tests++; if (instr_d !== 32'h0109_5020 || pc_plus4_d !== 32'h0040_0008) begin n_fail++; $display("FAIL nf_ifid: got %h/%h expected 01095020/00400008", instr_d, pc_plus4_d); end
        n_tests++; if (instr_e !== 32'h8C08_0000 || ctrl_e !== 12'h0A5 || valid_e !== 1'b1 || rf_wa_e !== 5'd10) begin n_fail++; $display("FAIL nf_idex_ctrl: got %h/%h/%b/%0d expected 8c080000/0a5/1/10", instr_e, ctrl_e, valid_e, rf_wa_e); end
        n_tests++; if (rd1_e !== 32'hAAAA_0001 || rd2_e !== 32'hBBBB_0002 || sext_imm_e !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL nf_idex_data: got %h/%h/%h expected aaaa0001/bbbb0002/fffffffc", rd1_e, rd2_e, sext_imm_e); end
        n_tests++; if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin n_fail++; $display("FAIL nf_cnt: got %0d/%0d expected 1/1", stall_cnt, flush_cnt); end
    endtask

    task automatic test_redirect();
        pc_src_d   = 1'b1;
        instr_f    = 32'h2009_0005;
        pc_plus4_f = 32'h0040_000C;
        pc_next_f  = 32'h0040_0100;
        step();
        n_tests++; if (instr_d !== 32'h0 || pc_plus4_d !== 32'h0 || valid_d !== 1'b0) begin n_fail++; $display("FAIL rd_squash: got %h/%h/%b expected 0/0/0", instr_d, pc_plus4_d, valid_d); end
        n_tests++; if (flush_cnt !== 16'd2 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL rd_cnt: got %0d/%0d expected 2/1", flush_cnt, stall_cnt); end
        n_tests++; if (instr_e !== 32'h0109_5020 || valid_e !== 1'b1) begin n_fail++; $display("FAIL rd_idex_prev: got %h/%b expected 01095020/1", instr_e, valid_e); end
        pc_src_d   = 1'b0;
        ctrl_d     = 12'h001;
        pc_plus4_f = 32'h0040_0104;
        step();
        n_tests++; if (ctrl_e !== 12'h0 || valid_e !== 1'b0 || instr_e !== 32'h0) begin n_fail++; $display("FAIL rd_mask: got ctrl %h valid %b instr %h expected 0/0/0", ctrl_e, valid_e, instr_e); end
        n_tests++; if (instr_d !== 32'h2009_0005 || valid_d !== 1'b1 || flush_cnt !== 16'd2) begin n_fail++; $display("FAIL rd_refill: got %h/%b/%0d expected 20090005/1/2", instr_d, valid_d, flush_cnt); end
    endtask

    task automatic test_stall_beats_redirect();
        stall_d   = 1'b1;
        pc_src_d  = 1'b1;
        instr_f   = 32'hDEAD_BEEF;
        pc_next_f = 32'h0040_0200;
        step();
        n_tests++; if (instr_d !== 32'h2009_0005 || valid_d !== 1'b1 || pc_plus4_d !== 32'h0040_0104) begin n_fail++; $display("FAIL sbr_hold: got %h/%b/%h expected 20090005/1/00400104", instr_d, valid_d, pc_plus4_d); end
        n_tests++; if (flush_cnt !== 16'd2 || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL sbr_cnt: got %0d/%0d expected 2/2", flush_cnt, stall_cnt); end
        n_tests++; if (pc_f !== 32'h0040_0200) begin n_fail++; $display("FAIL sbr_pc_indep: got %h expected 00400200", pc_f); end
        n_tests++; if (ctrl_e !== 12'h001 || valid_e !== 1'b1) begin n_fail++; $display("FAIL sbr_idex: got %h/%b expected 001/1", ctrl_e, valid_e); end
        ctrl_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            instr_f = 32'h1000_0000 + i;
            exp_q.push_back(32'h1000_0000 + i);
            step();
            n_tests++; if (instr_d !== 32'h1000_0000 + i) begin n_fail++; $display("FAIL b2b_ifid[%0d]: got %h expected %h", i, instr_d, 32'h1000_0000 + i); end
            if (i >= 1) begin
                exp_v = exp_q.pop_front();
                n_tests++; if (instr_e !== exp_v) begin n_fail++; $display("FAIL b2b_idex[%0d]: got %h expected %h", i, instr_e, exp_v); end
            end
        end
        instr_f = 32'h0;
        step();
        exp_v = exp_q.pop_front();
        n_tests++; if (instr_e !== exp_v) begin n_fail++; $display("FAIL b2b_idex_tail: got %h expected %h", instr_e, exp_v); end
    endtask

    task automatic test_double_flush();
        cnt_clr = 1'b1;
        step();
        n_tests++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        cnt_clr  = 1'b0;
        clr_e    = 1'b1;
        pc_src_d = 1'b1;
        step();
        n_tests++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL df_once: got %0d/%0d expected 1/0", flush_cnt, stall_cnt); end
        ctrl_idle();
    endtask

    task automatic test_saturation();
        stall_d = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall: got %h expected ffff", stall_cnt); end
        n_tests++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_flush_quiet: got %0d expected 1", flush_cnt); end
        cnt_clr = 1'b1;
        step();
        n_tests++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin n_fail++; $display("FAIL sat_clr: got %h/%h expected 0/0", stall_cnt, flush_cnt); end
        cnt_clr = 1'b0;
        step();
        n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_restart: got %0d expected 1", stall_cnt); end
        ctrl_idle();
    endtask

    task automatic test_async_reset();
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        pc_src_d  = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (pc_f !== RST_PC || instr_d !== 32'h0 || valid_d !== 1'b0) begin n_fail++; $display("FAIL ar_front: got %h/%h/%b expected 00400000/0/0", pc_f, instr_d, valid_d); end
        n_tests++; if (valid_e !== 1'b0 || ctrl_e !== 12'h0 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin n_fail++; $display("FAIL ar_back: got %b/%h/%h/%h expected 0/0/0/0", valid_e, ctrl_e, stall_cnt, flush_cnt); end
        ctrl_idle();
        pc_next_f = 32'h0040_0004;
        instr_f   = 32'h8C08_0000;
        #1;
        rst_n = 1'b1;
        step();
        n_tests++; if (pc_f !== 32'h0040_0004 || valid_d !== 1'b1 || stall_cnt !== 16'h0) begin n_fail++; $display("FAIL ar_resume: got %h/%b/%0d expected 00400004/1/0", pc_f, valid_d, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_normal_flow();
        test_redirect();
        test_stall_beats_redirect();
        test_back_to_back();
        test_double_flush();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
